// File: rtl/sdram_arbiter.sv
// ============================================================================
// sdram_arbiter : round-robin two-port arbiter for the SDRAM FIFO control port
//                 with an in-order tag queue steering read data back.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sdram_arbiter #(
   parameter int ADDR_WIDTH      = 24,
   parameter int DATA_WIDTH      = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] req0_addr_i,
   input  logic [DATA_WIDTH-1:0] req0_wr_data_i,
   input  logic                  req0_wr_i,
   input  logic                  req0_rd_i,
   output logic                  req0_ack_o,
   output logic [DATA_WIDTH-1:0] req0_rd_data_o,
   output logic                  req0_rd_valid_o,
   input  logic [ADDR_WIDTH-1:0] req1_addr_i,
   input  logic [DATA_WIDTH-1:0] req1_wr_data_i,
   input  logic                  req1_wr_i,
   input  logic                  req1_rd_i,
   output logic                  req1_ack_o,
   output logic [DATA_WIDTH-1:0] req1_rd_data_o,
   output logic                  req1_rd_valid_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wr_data_o,
   output logic                  ram_wr_en_o,
   output logic                  ram_rd_en_o,
   input  logic                  ram_busy_i,
   input  logic                  ram_rd_ready_i,
   input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
   output logic                  ram_rd_ack_o,
   output logic                  err_spurious_o
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
   logic                  ram_wr_en_q, ram_wr_en_d;
   logic                  ram_rd_en_q, ram_rd_en_d;
   logic                  ram_rd_ack_q, ram_rd_ack_d;
   logic [DATA_WIDTH-1:0] rd_data0_q, rd_data0_d;
   logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
   logic                  rd_valid0_q, rd_valid0_d;
   logic                  rd_valid1_q, rd_valid1_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic                  tags_q [MAX_OUTSTANDING];

   logic full, elig0, elig1, grant0, grant1, grant, sel_wr;
   logic push, pop, tag_pop, head_tag;

   // Issue side: round-robin among eligible ports, IDLE only
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      ram_addr_d    = ram_addr_q;
      ram_wr_data_d = ram_wr_data_q;
      ram_wr_en_d   = 1'b0;
      ram_rd_en_d   = 1'b0;
      grant0        = 1'b0;
      grant1        = 1'b0;

      full  = (count_q == CNT_W'(MAX_OUTSTANDING));
      elig0 = req0_wr_i | (req0_rd_i & ~full);
      elig1 = req1_wr_i | (req1_rd_i & ~full);

      if (state_q == ST_IDLE && !ram_busy_i) begin
         if (elig0 && (!elig1 || last_q)) begin
            grant0 = 1'b1;
         end else if (elig1) begin
            grant1 = 1'b1;
         end
      end
      grant  = grant0 | grant1;
      // Write takes precedence when a port holds both wr and rd
      sel_wr = grant1 ? req1_wr_i : req0_wr_i;
      push   = grant & ~sel_wr;

      if (grant) begin
         state_d       = ST_ISSUE;
         last_d        = grant1;
         ram_addr_d    = grant1 ? req1_addr_i : req0_addr_i;
         ram_wr_data_d = grant1 ? req1_wr_data_i : req0_wr_data_i;
         ram_wr_en_d   = sel_wr;
         ram_rd_en_d   = ~sel_wr;
      end else if (state_q == ST_ISSUE) begin
         state_d = ST_IDLE;
      end
   end

   // Return side: pop one word every other cycle at most
   always_comb begin
      pop          = ram_rd_ready_i & ~ram_rd_ack_q;
      tag_pop      = pop & (count_q != '0);
      head_tag     = tags_q[rd_ptr_q];
      ram_rd_ack_d = pop;
      rd_valid0_d  = tag_pop & ~head_tag;
      rd_valid1_d  = tag_pop & head_tag;
      rd_data0_d   = (tag_pop && !head_tag) ? ram_rd_data_i : rd_data0_q;
      rd_data1_d   = (tag_pop && head_tag) ? ram_rd_data_i : rd_data1_q;
      err_d        = err_q | (pop & (count_q == '0));
      wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d     = tag_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d      = count_q;
      if (push && !tag_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && tag_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         last_q        <= 1'b1;
         ram_addr_q    <= '0;
         ram_wr_data_q <= '0;
         ram_wr_en_q   <= 1'b0;
         ram_rd_en_q   <= 1'b0;
         ram_rd_ack_q  <= 1'b0;
         rd_data0_q    <= '0;
         rd_data1_q    <= '0;
         rd_valid0_q   <= 1'b0;
         rd_valid1_q   <= 1'b0;
         err_q         <= 1'b0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tags_q[i] <= 1'b0;
         end
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         ram_addr_q    <= ram_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         ram_wr_en_q   <= ram_wr_en_d;
         ram_rd_en_q   <= ram_rd_en_d;
         ram_rd_ack_q  <= ram_rd_ack_d;
         rd_data0_q    <= rd_data0_d;
         rd_data1_q    <= rd_data1_d;
         rd_valid0_q   <= rd_valid0_d;
         rd_valid1_q   <= rd_valid1_d;
         err_q         <= err_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         if (push) begin
            tags_q[wr_ptr_q] <= grant1;
         end
      end
   end

   assign req0_ack_o      = grant0;
   assign req1_ack_o      = grant1;
   assign req0_rd_data_o  = rd_data0_q;
   assign req1_rd_data_o  = rd_data1_q;
   assign req0_rd_valid_o = rd_valid0_q;
   assign req1_rd_valid_o = rd_valid1_q;
   assign ram_addr_o      = ram_addr_q;
   assign ram_wr_data_o   = ram_wr_data_q;
   assign ram_wr_en_o     = ram_wr_en_q;
   assign ram_rd_en_o     = ram_rd_en_q;
   assign ram_rd_ack_o    = ram_rd_ack_q;
   assign err_spurious_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// tb_sdram_arbiter : self-checking bench for sdram_arbiter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] req0_addr_i, req1_addr_i;
   logic [15:0] req0_wr_data_i, req1_wr_data_i;
   logic        req0_wr_i, req0_rd_i, req1_wr_i, req1_rd_i;
   logic        req0_ack_o, req1_ack_o;
   logic [15:0] req0_rd_data_o, req1_rd_data_o;
   logic        req0_rd_valid_o, req1_rd_valid_o;
   logic [23:0] ram_addr_o;
   logic [15:0] ram_wr_data_o;
   logic        ram_wr_en_o, ram_rd_en_o;
   logic        ram_busy_i, ram_rd_ready_i;
   logic [15:0] ram_rd_data_i;
   logic        ram_rd_ack_o, err_spurious_o;

   sdram_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(16), .MAX_OUTSTANDING(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .req0_addr_i     (req0_addr_i),
      .req0_wr_data_i  (req0_wr_data_i),
      .req0_wr_i       (req0_wr_i),
      .req0_rd_i       (req0_rd_i),
      .req0_ack_o      (req0_ack_o),
      .req0_rd_data_o  (req0_rd_data_o),
      .req0_rd_valid_o (req0_rd_valid_o),
      .req1_addr_i     (req1_addr_i),
      .req1_wr_data_i  (req1_wr_data_i),
      .req1_wr_i       (req1_wr_i),
      .req1_rd_i       (req1_rd_i),
      .req1_ack_o      (req1_ack_o),
      .req1_rd_data_o  (req1_rd_data_o),
      .req1_rd_valid_o (req1_rd_valid_o),
      .ram_addr_o      (ram_addr_o),
      .ram_wr_data_o   (ram_wr_data_o),
      .ram_wr_en_o     (ram_wr_en_o),
      .ram_rd_en_o     (ram_rd_en_o),
      .ram_busy_i      (ram_busy_i),
      .ram_rd_ready_i  (ram_rd_ready_i),
      .ram_rd_data_i   (ram_rd_data_i),
      .ram_rd_ack_o    (ram_rd_ack_o),
      .err_spurious_o  (err_spurious_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w0, r0, w1, r1, busy;
      logic        ack0, ack1, wen, ren;
      logic [23:0] addr;
      logic [15:0] wdata;
   } vec_t;

   typedef struct {
      logic        port;
      logic [15:0] d;
   } sb_t;

   typedef struct {
      logic [15:0] d;
      int          due;
   } ram_t;

   vec_t tbl [13];
   sb_t  sb [$];
   ram_t mq [$];
   sb_t  e;
   int   n_pass  = 0;
   int   n_total = 0;
   int   n0, n1, g;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_wr_i = 0; req0_rd_i = 0; req1_wr_i = 0; req1_rd_i = 0;
      ram_busy_i = 0; ram_rd_ready_i = 0; ram_rd_data_i = 16'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      #1;
      chk("rst_ack0", req0_ack_o, 0);
      chk("rst_ack1", req1_ack_o, 0);
      chk("rst_addr", ram_addr_o, 0);
      chk("rst_wdata", ram_wr_data_o, 0);
      chk("rst_wen", ram_wr_en_o, 0);
      chk("rst_ren", ram_rd_en_o, 0);
      chk("rst_rdack", ram_rd_ack_o, 0);
      chk("rst_rdata0", req0_rd_data_o, 0);
      chk("rst_rdata1", req1_rd_data_o, 0);
      chk("rst_valid0", req0_rd_valid_o, 0);
      chk("rst_valid1", req1_rd_valid_o, 0);
      chk("rst_err", err_spurious_o, 0);
   endtask

   function automatic logic [15:0] rd_word(input logic [23:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      req0_addr_i = 24'h000010; req0_wr_data_i = 16'hBEEF;
      req1_addr_i = 24'h000020; req1_wr_data_i = 16'h5555;
      idle_inputs();
      rst = 1'b1;
      tick();
      do_reset();
      chk_reset_outputs();

      // w0 r0 w1 r1 busy | ack0 ack1 wen ren | addr wdata
      tbl[0]  = '{1,0,0,0,0, 1,0,0,0, 24'h0,      16'h0};
      tbl[1]  = '{0,0,0,0,0, 0,0,1,0, 24'h000010, 16'hBEEF};
      tbl[2]  = '{0,0,0,0,0, 0,0,0,0, 24'h0,      16'h0};
      tbl[3]  = '{1,0,1,0,0, 0,1,0,0, 24'h0,      16'h0};
      tbl[4]  = '{1,0,0,0,0, 0,0,1,0, 24'h000020, 16'h5555};
      tbl[5]  = '{1,0,0,0,0, 1,0,0,0, 24'h0,      16'h0};
      tbl[6]  = '{0,0,0,0,0, 0,0,1,0, 24'h000010, 16'hBEEF};
      tbl[7]  = '{1,0,1,0,1, 0,0,0,0, 24'h0,      16'h0};
      tbl[8]  = '{1,0,1,0,1, 0,0,0,0, 24'h0,      16'h0};
      tbl[9]  = '{1,0,1,0,0, 0,1,0,0, 24'h0,      16'h0};
      tbl[10] = '{0,0,0,0,0, 0,0,1,0, 24'h000020, 16'h5555};
      tbl[11] = '{1,1,0,0,0, 1,0,0,0, 24'h0,      16'h0};
      tbl[12] = '{0,0,0,0,0, 0,0,1,0, 24'h000010, 16'hBEEF};

      for (int i = 0; i < 13; i++) begin
         req0_wr_i = tbl[i].w0; req0_rd_i = tbl[i].r0;
         req1_wr_i = tbl[i].w1; req1_rd_i = tbl[i].r1;
         ram_busy_i = tbl[i].busy;
         #1;
         chk($sformatf("vec%0d_ack0", i), req0_ack_o, tbl[i].ack0);
         chk($sformatf("vec%0d_ack1", i), req1_ack_o, tbl[i].ack1);
         chk($sformatf("vec%0d_wen", i), ram_wr_en_o, tbl[i].wen);
         chk($sformatf("vec%0d_ren", i), ram_rd_en_o, tbl[i].ren);
         if (tbl[i].wen || tbl[i].ren) begin
            chk($sformatf("vec%0d_addr", i), ram_addr_o, tbl[i].addr);
            chk($sformatf("vec%0d_wdata", i), ram_wr_data_o, tbl[i].wdata);
         end
         tick();
      end

      // ram_busy held 10 cycles with both ports writing
      idle_inputs();
      req0_wr_i = 1; req1_wr_i = 1; ram_busy_i = 1;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("busy_no_ack", {req0_ack_o, req1_ack_o}, 0);
         chk("busy_no_strobe", {ram_wr_en_o, ram_rd_en_o}, 0);
         tick();
      end
      ram_busy_i = 0;
      #1;
      chk("busy_fall_ack1", req1_ack_o, 1);
      chk("busy_fall_ack0", req0_ack_o, 0);
      tick();
      idle_inputs();
      #1;
      chk("busy_fall_wen", ram_wr_en_o, 1);
      chk("busy_fall_addr", ram_addr_o, 24'h000020);
      tick();

      // Alternating reads, RAM model returns 3 cycles after each strobe
      do_reset();
      sb.delete(); mq.delete();
      for (int k = 0; k < 4; k++) begin
         sb.push_back('{1'b0, rd_word(24'h000100 + 24'(k))});
         sb.push_back('{1'b1, rd_word(24'h000200 + 24'(k))});
      end
      n0 = 0; n1 = 0; g = 0;
      for (int cyc = 0; cyc < 100 && sb.size() != 0; cyc++) begin
         if (ram_rd_ack_o && mq.size() != 0) void'(mq.pop_front());
         if (ram_rd_en_o) mq.push_back('{rd_word(ram_addr_o), cyc + 3});
         if (req0_rd_valid_o || req1_rd_valid_o) begin
            if (sb.size() == 0) begin
               chk("sb_extra_word", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rr_return_port", req1_rd_valid_o, e.port);
               chk("rr_return_data", e.port ? req1_rd_data_o : req0_rd_data_o, e.d);
            end
         end
         ram_rd_ready_i = (mq.size() != 0) && (mq[0].due <= cyc);
         ram_rd_data_i  = (mq.size() != 0) ? mq[0].d : 16'h0;
         req0_rd_i   = (n0 < 4);
         req1_rd_i   = (n1 < 4);
         req0_addr_i = 24'h000100 + 24'(n0);
         req1_addr_i = 24'h000200 + 24'(n1);
         #1;
         if (req0_ack_o || req1_ack_o) begin
            chk("rr_grant_port", req1_ack_o, g % 2);
            g++;
            if (req0_ack_o) n0++;
            if (req1_ack_o) n1++;
         end
         tick();
      end
      chk("rr_all_returned", sb.size(), 0);
      chk("rr_grants", g, 8);

      // Tag queue full: port 1 reads with nothing returned
      do_reset();
      req1_addr_i = 24'h000300;
      req1_rd_i = 1;
      n1 = 0;
      for (int c = 0; c < 20 && n1 < 4; c++) begin
         #1;
         if (req1_ack_o) n1++;
         tick();
      end
      chk("full_four_reads", n1, 4);
      #1;
      chk("full_issue_no_ack", req1_ack_o, 0);
      tick();
      #1;
      chk("full_blocks_read", req1_ack_o, 0);
      tick();
      req0_addr_i = 24'h000030; req0_wr_data_i = 16'h1234; req0_wr_i = 1;
      #1;
      chk("full_write_ack0", req0_ack_o, 1);
      chk("full_write_ack1", req1_ack_o, 0);
      tick();
      req0_wr_i = 0;
      ram_rd_ready_i = 1; ram_rd_data_i = 16'hC0DE;
      #1;
      chk("full_wen", ram_wr_en_o, 1);
      chk("full_wdata", ram_wr_data_o, 16'h1234);
      chk("full_pop_cycle_ack1", req1_ack_o, 0);
      tick();
      ram_rd_ready_i = 0;
      #1;
      chk("full_rdack", ram_rd_ack_o, 1);
      chk("full_valid1", req1_rd_valid_o, 1);
      chk("full_valid0", req0_rd_valid_o, 0);
      chk("full_rdata1", req1_rd_data_o, 16'hC0DE);
      chk("full_fifth_ack", req1_ack_o, 1);
      tick();
      req1_rd_i = 0;
      #1;
      chk("full_fifth_ren", ram_rd_en_o, 1);
      chk("full_fifth_addr", ram_addr_o, 24'h000300);
      tick();

      // Reset with reads outstanding, then a word arrives with no tag
      do_reset();
      chk_reset_outputs();
      tick();
      ram_rd_ready_i = 1; ram_rd_data_i = 16'hAAAA;
      tick();
      ram_rd_ready_i = 0;
      #1;
      chk("spur_rdack", ram_rd_ack_o, 1);
      chk("spur_valid", {req0_rd_valid_o, req1_rd_valid_o}, 0);
      chk("spur_err", err_spurious_o, 1);
      tick();
      #1;
      chk("spur_single_ack", ram_rd_ack_o, 0);
      tick(); tick(); tick();
      #1;
      chk("spur_err_sticky", err_spurious_o, 1);
      do_reset();
      #1;
      chk("spur_err_cleared", err_spurious_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
